// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
package clk_div_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    // Half-period in input clock cycles for a requested output frequency.
    function automatic int unsigned half_from_freq(input int unsigned clk_in,
                                                   input int unsigned f_out);
        return clk_in / f_out / 2;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Counter datapath: counts each level, toggles clk_div at boundaries and
// produces the rise/fall ticks. Holds the half-period currently in use.
module clk_div_core #(
    parameter int          CNT_W    = 32,
    parameter int unsigned DEF_HALF = 10000000
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             start,
    input  logic             clear,
    input  logic             load_half,
    input  logic [CNT_W-1:0] half_in,
    output logic             boundary,
    output logic             clk_div,
    output logic             tick_rise,
    output logic             tick_fall
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active_half;

    assign boundary = run && (count == active_half - CNT_W'(1));

    // A boundary load takes effect for the level that starts at this edge,
    // since the new level is counted against active_half from the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            clk_div     <= 1'b0;
            tick_rise   <= 1'b0;
            tick_fall   <= 1'b0;
            active_half <= CNT_W'(DEF_HALF);
        end else begin
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            if (load_half)
                active_half <= half_in;
            if (start) begin
                clk_div   <= 1'b1;
                tick_rise <= 1'b1;
                count     <= '0;
            end else if (clear) begin
                clk_div <= 1'b0;
                count   <= '0;
            end else if (boundary) begin
                count     <= '0;
                clk_div   <= !clk_div;
                tick_rise <= !clk_div;
                tick_fall <= clk_div;
            end else if (run) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop sequencing and half-period reconfiguration for the clock divider,
// guaranteeing every high and low level of clk_div is full length.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CLK_IN   = 20000000,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_HALF = half_from_freq(CLK_IN, 1)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             busy
);

    state_t           state;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_half;
    logic             accept;
    logic             cfg_zero;
    logic             boundary;
    logic             run;
    logic             start;
    logic             clear;
    logic             load_half;

    assign accept    = cfg_valid && cfg_ready;
    assign cfg_zero  = (cfg_half == '0);
    assign run       = (state != IDLE);
    assign start     = (state == IDLE) && en;
    // Dropping en while low stops at once: the output is already low.
    assign clear     = (state == RUN) && !en && !clk_div;
    assign load_half = pend_valid && ((state == IDLE) || boundary);

    clk_div_core #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .start     (start),
        .clear     (clear),
        .load_half (load_half),
        .half_in   (pend_half),
        .boundary  (boundary),
        .clk_div   (clk_div),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall)
    );

    // Accept and apply are exclusive: accepting needs pend_valid low, applying needs it high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pend_valid <= 1'b0;
            pend_half  <= '0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= accept && cfg_zero;
            if (accept && !cfg_zero) begin
                pend_valid <= 1'b1;
                pend_half  <= cfg_half;
                cfg_ready  <= 1'b0;
            end else if (load_half) begin
                pend_valid <= 1'b0;
                cfg_ready  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        if (!clk_div || boundary) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (en) begin
                        state <= RUN;
                    end else if (boundary) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl with DEF_HALF=3: vector table, directed
// corner sequences, then random traffic against a level-countdown model.
module tb_clk_div_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic [31:0] cfg_half;
    logic        cfg_ready;
    logic        cfg_err;
    logic        clk_div;
    logic        tick_rise;
    logic        tick_fall;
    logic        busy;

    int n_tests;
    int n_fail;

    clk_div_ctrl #(
        .CLK_IN   (20000000),
        .CNT_W    (32),
        .DEF_HALF (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_div   (clk_div),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector order: {clk_div, tick_rise, tick_fall, cfg_err, busy, cfg_ready}
    typedef struct {
        logic        en;
        logic        valid;
        logic [31:0] half;
        logic        rst;
        logic [5:0]  exp;
    } vec_t;

    vec_t tbl[18];

    // Reference model: tracks the current level and how many cycles of it remain.
    bit  m_on;
    bit  m_lvl;
    int  m_left;
    int  m_half;
    int  m_pend[$];
    logic [5:0] m_exp;

    task automatic modelStep(input logic en_i, input logic valid_i,
                             input logic [31:0] half_i, input logic rst_i);
        bit rise, fall, err, accept, eol;
        rise = 0; fall = 0; err = 0;
        if (rst_i) begin
            m_on = 0; m_lvl = 0; m_left = 0; m_half = 3;
            m_pend.delete();
        end else begin
            accept = valid_i && (m_pend.size() == 0);
            err    = accept && (half_i == 0);
            if (!m_on) begin
                if (m_pend.size() != 0) m_half = m_pend.pop_front();
                if (en_i) begin
                    m_on = 1; m_lvl = 1; m_left = m_half; rise = 1;
                end
            end else begin
                eol = (m_left == 1);
                if (eol && m_pend.size() != 0) m_half = m_pend.pop_front();
                if (!en_i && !m_lvl) begin
                    m_on = 0;
                end else if (eol) begin
                    m_lvl  = !m_lvl;
                    m_left = m_half;
                    if (m_lvl) rise = 1; else fall = 1;
                    if (!m_lvl && !en_i) m_on = 0;
                end else begin
                    m_left = m_left - 1;
                end
            end
            if (accept && half_i != 0) m_pend.push_back(int'(half_i));
        end
        m_exp = {m_lvl, rise, fall, err, m_on, (m_pend.size() == 0)};
    endtask

    task automatic applyStimulus(input logic en_i, input logic valid_i,
                                 input logic [31:0] half_i, input logic rst_i);
        @(negedge clk);
        en        = en_i;
        cfg_valid = valid_i;
        cfg_half  = half_i;
        rst       = rst_i;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {clk_div, tick_rise, tick_fall, cfg_err, busy, cfg_ready};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b (clk_div,rise,fall,err,busy,ready)",
                     name, got, exp);
        end
    endtask

    task automatic step(input logic en_i, input logic valid_i, input logic [31:0] half_i,
                        input logic rst_i, input logic [5:0] exp, input string name);
        applyStimulus(en_i, valid_i, half_i, rst_i);
        checkOutput(name, exp);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;

        // Basic waveform, zero-config rejection, stop during a high level
        tbl[0]  = '{1'b0, 1'b0, 32'd0, 1'b1, 6'b000001};
        tbl[1]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b110011};
        tbl[2]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b100011};
        tbl[3]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b100011};
        tbl[4]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b001011};
        tbl[5]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b000011};
        tbl[6]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b000011};
        tbl[7]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b110011};
        tbl[8]  = '{1'b1, 1'b1, 32'd0, 1'b0, 6'b100111};
        tbl[9]  = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b100011};
        tbl[10] = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b001011};
        tbl[11] = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b000011};
        tbl[12] = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b000011};
        tbl[13] = '{1'b1, 1'b0, 32'd0, 1'b0, 6'b110011};
        tbl[14] = '{1'b0, 1'b0, 32'd0, 1'b0, 6'b100011};
        tbl[15] = '{1'b0, 1'b0, 32'd0, 1'b0, 6'b100011};
        tbl[16] = '{1'b0, 1'b0, 32'd0, 1'b0, 6'b001001};
        tbl[17] = '{1'b0, 1'b0, 32'd0, 1'b0, 6'b000001};

        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].en, tbl[i].valid, tbl[i].half, tbl[i].rst);
            checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Reconfigure to H=5 accepted at count 0 of a high level
        step(1'b0, 1'b0, 32'd0, 1'b1, 6'b000001, "recfg reset");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b110011, "recfg start");
        step(1'b1, 1'b1, 32'd5, 1'b0, 6'b100010, "recfg accept");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b100010, "recfg pending");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b001011, "recfg old high ends");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 32'd0, 1'b0, 6'b000011, $sformatf("recfg low5[%0d]", i));
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b110011, "recfg low5 ends");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 32'd0, 1'b0, 6'b100011, $sformatf("recfg high5[%0d]", i));
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b001011, "recfg high5 ends");

        // Drop en during a low level: idle at once, no tick
        step(1'b0, 1'b0, 32'd0, 1'b0, 6'b000001, "stop in low");

        // Re-raise en during STOP: high still lasts 5 cycles
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b110011, "restart");
        step(1'b0, 1'b0, 32'd0, 1'b0, 6'b100011, "enter stop");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 32'd0, 1'b0, 6'b100011, $sformatf("cancel stop[%0d]", i));
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b001011, "cancel stop fall");

        // Reset mid-run with a pending config
        step(1'b1, 1'b1, 32'd2, 1'b0, 6'b000010, "pend before reset");
        step(1'b1, 1'b0, 32'd0, 1'b1, 6'b000001, "mid-run reset");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b110011, "post-reset start");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b100011, "post-reset high1");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b100011, "post-reset high2");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b001011, "post-reset default half");

        // H=1 configured in idle
        step(1'b0, 1'b0, 32'd0, 1'b0, 6'b000001, "h1 to idle");
        step(1'b0, 1'b1, 32'd1, 1'b0, 6'b000000, "h1 accept");
        step(1'b0, 1'b0, 32'd0, 1'b0, 6'b000001, "h1 applied idle");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b110011, "h1 rise0");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b001011, "h1 fall0");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b110011, "h1 rise1");
        step(1'b1, 1'b0, 32'd0, 1'b0, 6'b001011, "h1 fall1");

        // Random traffic against the reference model
        begin
            logic        r_en, r_valid, r_rst;
            logic [31:0] r_half;
            r_en = 1'b0;
            modelStep(1'b0, 1'b0, 32'd0, 1'b1);
            step(1'b0, 1'b0, 32'd0, 1'b1, m_exp, "random reset");
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) r_en = !r_en;
                r_valid = ($urandom_range(0, 3) == 0);
                r_half  = $urandom_range(0, 4);
                r_rst   = ($urandom_range(0, 99) == 0);
                modelStep(r_en, r_valid, r_half, r_rst);
                step(r_en, r_valid, r_half, r_rst, m_exp, $sformatf("random[%0d]", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
